data_mem_responder: RTL and testbench

Responder (memory side) of the core's load/store data-memory interface. Accepts the lane-positioned write data and byte mask, and returns full 32-bit words for loads. Lane extraction and sign-extension stay in the core. Adds a parameterised registered read pipeline with a valid strobe, range and mask checking with sticky error flags, and load/store access counters for compliance runs.

---
 rtl/data_mem_responder.sv | 158 +++++++++++++++
 tb/tb_data_mem_responder.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_responder.sv
// Purpose : memory-side responder for the core's load/store data port.
//           Byte-masked stores into a word array, and word loads returned
//           through a READ_LAT-deep registered pipeline with a valid strobe.
//           Checks address range and store masks into sticky flags, and
//           counts accepted loads and stores.
// Ports   : clk, rst (sync, active-high); cs (active-low), wr (1 = load),
//           mask, addr, data_wr  -> request;  err_clr -> clears flags;
//           data_rd, rd_valid    -> load response;
//           err_oor, err_mask    -> sticky error flags;
//           load_cnt, store_cnt  -> accepted-request counters.
module data_mem_responder #(
  parameter int          DEPTH     = 1024,
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int          READ_LAT  = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cs,
  input  logic        wr,
  input  logic [3:0]  mask,
  input  logic [31:0] addr,
  input  logic [31:0] data_wr,
  input  logic        err_clr,
  output logic [31:0] data_rd,
  output logic        rd_valid,
  output logic        err_oor,
  output logic        err_mask,
  output logic [31:0] load_cnt,
  output logic [31:0] store_cnt
);

  localparam int AW = $clog2(DEPTH);

  logic [31:0] mem [DEPTH];

  // Address decode: everything is relative to BASE_ADDR. Because DEPTH is a
  // power of two, "offset < 4*DEPTH" is simply "upper offset bits are zero".
  logic [31:0]   offset;
  logic          in_range;
  logic [AW-1:0] word_idx;
  logic          unused_lsb;

  assign offset     = addr - BASE_ADDR;
  assign in_range   = (offset[31:AW+2] == '0);
  assign word_idx   = offset[AW+1:2];
  assign unused_lsb = ^offset[1:0];

  logic load_req;
  logic store_req;

  assign load_req  = !cs && wr;
  assign store_req = !cs && !wr;

  // Legal masks are naturally aligned byte, halfword and word lanes.
  // An all-zero mask is a harmless no-op store, not an error.
  logic mask_ok;

  always_comb begin
    mask_ok = 1'b0;
    case (mask)
      4'b0000, 4'b0001, 4'b0010, 4'b0100, 4'b1000,
      4'b0011, 4'b1100, 4'b1111: mask_ok = 1'b1;
      default:                   mask_ok = 1'b0;
    endcase
  end

  logic do_write;

  assign do_write = store_req && in_range && mask_ok && !rst;

  // Array is deliberately not reset so contents survive a core reset.
  always_ff @(posedge clk) begin
    if (do_write) begin
      for (int i = 0; i < 4; i++) begin
        if (mask[i]) begin
          mem[word_idx][8*i +: 8] <= data_wr[8*i +: 8];
        end
      end
    end
  end

  // Out-of-range loads still travel the pipeline so latency is uniform.
  logic [31:0] rd_word;

  assign rd_word = in_range ? mem[word_idx] : 32'h0;

  // Read pipeline: stage 0 captures the array word at the request edge, the
  // last stage drives the outputs. Each stage only reloads its data when a
  // valid entry arrives, so data_rd holds its value between responses.
  logic [31:0]         pipe_dat [READ_LAT];
  logic [READ_LAT-1:0] pipe_vld;
  logic [31:0]         stg_dat  [READ_LAT];
  logic [READ_LAT-1:0] stg_vld;

  always_comb begin
    stg_vld    = '0;
    stg_vld[0] = load_req;
    stg_dat[0] = rd_word;
    for (int i = 1; i < READ_LAT; i++) begin
      stg_vld[i] = pipe_vld[i-1];
      stg_dat[i] = pipe_dat[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) begin
        pipe_dat[i] <= 32'h0;
      end
    end else begin
      pipe_vld <= stg_vld;
      for (int i = 0; i < READ_LAT; i++) begin
        if (stg_vld[i]) begin
          pipe_dat[i] <= stg_dat[i];
        end
      end
    end
  end

  assign data_rd  = pipe_dat[READ_LAT-1];
  assign rd_valid = pipe_vld[READ_LAT-1];

  // Sticky flags: a fresh error in the same cycle as err_clr takes priority.
  always_ff @(posedge clk) begin
    if (rst) begin
      err_oor  <= 1'b0;
      err_mask <= 1'b0;
    end else begin
      if (err_clr) begin
        err_oor  <= 1'b0;
        err_mask <= 1'b0;
      end
      if ((load_req || store_req) && !in_range) begin
        err_oor <= 1'b1;
      end
      if (store_req && !mask_ok) begin
        err_mask <= 1'b1;
      end
    end
  end

  // Counters wrap naturally at 2^32.
  always_ff @(posedge clk) begin
    if (rst) begin
      load_cnt  <= 32'h0;
      store_cnt <= 32'h0;
    end else begin
      if (load_req) begin
        load_cnt <= load_cnt + 32'd1;
      end
      if (store_req) begin
        store_cnt <= store_cnt + 32'd1;
      end
    end
  end

endmodule

// File: tb/tb_data_mem_responder.sv
// Purpose : directed bench for data_mem_responder (DEPTH=64, non-zero base,
//           READ_LAT=3). Loads push their expected word and issue edge into
//           a queue; a monitor pops on every rd_valid and checks data/timing.
// Ports   : none (top-level bench).
module tb_data_mem_responder;

  localparam int          DEPTH = 64;
  localparam logic [31:0] BASE  = 32'h1000_0000;
  localparam int          LAT   = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        cs;
  logic        wr;
  logic [3:0]  mask;
  logic [31:0] addr;
  logic [31:0] data_wr;
  logic        err_clr;
  logic [31:0] data_rd;
  logic        rd_valid;
  logic        err_oor;
  logic        err_mask;
  logic [31:0] load_cnt;
  logic [31:0] store_cnt;

  data_mem_responder #(.DEPTH(DEPTH), .BASE_ADDR(BASE), .READ_LAT(LAT)) dut (
    .clk(clk), .rst(rst), .cs(cs), .wr(wr), .mask(mask), .addr(addr),
    .data_wr(data_wr), .err_clr(err_clr), .data_rd(data_rd),
    .rd_valid(rd_valid), .err_oor(err_oor), .err_mask(err_mask),
    .load_cnt(load_cnt), .store_cnt(store_cnt)
  );

  always #5 clk = ~clk;

  // cyc = number of rising edges seen so far.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [31:0] dat;
    int          issue;
  } exp_t;

  exp_t exp_q[$];
  int   vectors    = 0;
  int   miscompares = 0;
  int   exp_loads  = 0;
  int   exp_stores = 0;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", name, act, req);
    end
  endtask

  // A load sampled at edge N is visible on the outputs after edge N+LAT-1,
  // i.e. LAT register stages counting the sampling register itself.
  always @(negedge clk) begin
    if (rd_valid) begin
      vectors++;
      if (exp_q.size() == 0) begin
        miscompares++;
        $display("FAIL spurious_rd_valid: rd_valid=1 with data %h at edge %0d, expected none",
                 data_rd, cyc);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        if (data_rd !== e.dat || cyc != e.issue + LAT - 1) begin
          miscompares++;
          $display("FAIL load_resp: data %h at edge %0d, expected %h at edge %0d",
                   data_rd, cyc, e.dat, e.issue + LAT - 1);
        end
      end
    end
  end

  // All tasks start and end 1 time unit after a rising edge; each request
  // occupies exactly one sampling edge.
  task automatic idle(input int n);
    cs = 1'b1;
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic do_store(input logic [31:0] a, input logic [31:0] d,
                          input logic [3:0] m);
    cs = 1'b0; wr = 1'b0; addr = a; data_wr = d; mask = m;
    exp_stores++;
    @(posedge clk);
    #1;
    cs = 1'b1; err_clr = 1'b0;
  endtask

  task automatic do_load(input logic [31:0] a, input logic [31:0] e,
                         input bit track);
    exp_t x;
    cs = 1'b0; wr = 1'b1; addr = a; mask = 4'h0;
    x.dat   = e;
    x.issue = cyc + 1;
    if (track) exp_q.push_back(x);
    exp_loads++;
    @(posedge clk);
    #1;
    cs = 1'b1; err_clr = 1'b0;
  endtask

  task automatic drain;
    int budget;
    budget = 30;
    while (exp_q.size() != 0 && budget > 0) begin
      @(posedge clk);
      #1;
      budget--;
    end
    vectors++;
    if (exp_q.size() != 0) begin
      miscompares++;
      $display("FAIL drain_timeout: %0d responses outstanding, expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation still running, expected finish");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1; cs = 1'b1; wr = 1'b0; mask = 4'h0; addr = 32'h0;
    data_wr = 32'h0; err_clr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    check("rst_rd_valid",  {31'h0, rd_valid}, 32'h0);
    check("rst_data_rd",   data_rd,   32'h0);
    check("rst_err_oor",   {31'h0, err_oor},  32'h0);
    check("rst_err_mask",  {31'h0, err_mask}, 32'h0);
    check("rst_load_cnt",  load_cnt,  32'h0);
    check("rst_store_cnt", store_cnt, 32'h0);

    // Full-word store then load back.
    do_store(BASE + 8, 32'hDEAD_BEEF, 4'b1111);
    do_load(BASE + 8, 32'hDEAD_BEEF, 1'b1);
    drain();
    check("cnt1_store", store_cnt, 32'd1);
    check("cnt1_load",  load_cnt,  32'd1);
    idle(3);
    check("data_rd_hold", data_rd, 32'hDEAD_BEEF);

    // Byte-lane merges; addr[1:0] must be ignored by the array.
    do_store(BASE + 12, 32'h1111_1111, 4'b1111);
    do_store(BASE + 13, 32'h0000_AA00, 4'b0010);
    do_store(BASE + 15, 32'h5500_0000, 4'b1000);
    do_load(BASE + 12, 32'h5511_AA11, 1'b1);
    drain();

    // Halfword store on the upper lanes.
    do_store(BASE + 0, 32'h1234_5678, 4'b1111);
    do_store(BASE + 0, 32'hCAFE_0000, 4'b1100);
    do_load(BASE + 0, 32'hCAFE_5678, 1'b1);

    // Back-to-back loads: four consecutive responses.
    do_store(BASE + 16, 32'd1, 4'b1111);
    do_store(BASE + 20, 32'd2, 4'b1111);
    do_store(BASE + 24, 32'd3, 4'b1111);
    do_store(BASE + 28, 32'd4, 4'b1111);
    do_load(BASE + 16, 32'd1, 1'b1);
    do_load(BASE + 20, 32'd2, 1'b1);
    do_load(BASE + 24, 32'd3, 1'b1);
    do_load(BASE + 28, 32'd4, 1'b1);
    drain();

    // Zero mask: accepted and counted, writes nothing, no error.
    do_store(BASE + 8, 32'hFFFF_FFFF, 4'b0000);
    check("mask0_no_err", {31'h0, err_mask}, 32'h0);
    do_load(BASE + 8, 32'hDEAD_BEEF, 1'b1);

    // Out of range: one word past the end (would alias word 0 if unchecked).
    do_store(BASE + 4*DEPTH, 32'hFFFF_FFFF, 4'b1111);
    check("oor_store_flag", {31'h0, err_oor}, 32'h1);
    do_load(BASE + 4*DEPTH, 32'h0, 1'b1);
    do_load(BASE + 0, 32'hCAFE_5678, 1'b1);
    // err_clr together with a new out-of-range access: flag stays set.
    err_clr = 1'b1;
    do_load(BASE - 4, 32'h0, 1'b1);
    check("oor_clr_collide", {31'h0, err_oor}, 32'h1);
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("oor_cleared", {31'h0, err_oor}, 32'h0);
    drain();

    // Illegal mask: flag, no write, still counted.
    do_store(BASE + 12, 32'hAAAA_AAAA, 4'b0110);
    check("mask_err_flag", {31'h0, err_mask}, 32'h1);
    check("mask_err_cnt",  store_cnt, exp_stores);
    do_load(BASE + 12, 32'h5511_AA11, 1'b1);
    drain();
    err_clr = 1'b1;
    idle(1);
    err_clr = 1'b0;
    check("mask_cleared", {31'h0, err_mask}, 32'h0);
    check("cnt2_load",  load_cnt,  exp_loads);
    check("cnt2_store", store_cnt, exp_stores);

    // Reset with a load in flight: that load must never respond, and a
    // store presented alongside rst must be ignored.
    do_load(BASE + 8, 32'h0, 1'b0);
    rst = 1'b1;
    cs = 1'b0; wr = 1'b0; addr = BASE + 8; data_wr = 32'h0BAD_0BAD; mask = 4'b1111;
    @(posedge clk);
    #1;
    rst = 1'b0; cs = 1'b1;
    exp_loads = 0; exp_stores = 0;
    idle(LAT + 3);
    check("rstmid_load_cnt",  load_cnt,  32'h0);
    check("rstmid_store_cnt", store_cnt, 32'h0);
    check("rstmid_data_rd",   data_rd,   32'h0);
    do_load(BASE + 8, 32'hDEAD_BEEF, 1'b1);
    do_load(BASE + 12, 32'h5511_AA11, 1'b1);
    drain();
    check("post_rst_load_cnt", load_cnt, 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
